alu_pipeline_p: RTL and testbench
=================================

# alu_pipeline_p

Parametrised three-stage integer pipeline: operand fetch, execute, writeback/store. It is the next generation of the team's fixed 16-bit, dual-clock ALU pipeline and adds several features:
- a single clock;
- configurable datapath, register-file and memory sizes;
- per-instruction valid and store enables;
- full operand forwarding, so back-to-back dependent instructions need no stall;
- illegal-opcode detection;
- a load-immediate op.

It sits between the instruction sequencer and the data memory, and is the sole writer of both the register bank and the memory bank.

## Interface
- DATA_W, 16, datapath and register width
- REG_AW, 4, register index width; bank has 2**REG_AW entries
- MEM_AW, 8, memory address width; bank has 2**MEM_AW words of DATA_W
- REG0_ZERO, 0, 1 = register 0 always reads 0 and ignores writes
- Clock  in  1  sole clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present this cycle
- func  in  4  opcode
- rs1, rs2, rd  in  REG_AW  source and destination register indices
- imm  in  DATA_W  immediate for LI
- st_en  in  1  also store the result to membank[addr]
- addr  in  MEM_AW  store address
- mem_raddr  in  MEM_AW  readback address
- mem_rdata  out  DATA_W  combinational membank[mem_raddr]
- Zout  out  DATA_W  writeback result
- Zout_valid  out  1  Zout/Zout_rd/err valid this cycle
- Zout_rd  out  REG_AW  destination of Zout
- err  out  1  illegal opcode retired this cycle

## Operation
**Opcodes.** Results are truncated to DATA_W; arithmetic is unsigned and wraps.
- 0 ADD: A+B
- 1 SUB: A−B
- 2 MUL: low DATA_W bits of A*B
- 3 MOVA: A
- 4 MOVB: B
- 5 AND: A&B
- 6 OR: A|B
- 7 XOR: A^B
- 8 NOTA: ~A
- 9 NOTB: ~B
- 10 SHR: A>>1, logical
- 11 SHL: B<<1
- 12 LI: imm
- 13 NOP: no register write and no store; still retires with Zout_valid=1 and Zout=0
- 14–15 illegal: Zout=0, err=1, no register write, no store

**Stages.**
- S1 captures the valid bit, func, rd, addr and st_en, plus operands A and B.
- S2 computes the result.
- S3 does the following:
  - writes regbank[rd] for legal non-NOP ops, suppressed if REG0_ZERO and rd=0;
  - writes membank[addr] when st_en is set and the op is legal non-NOP;
  - drives Zout, Zout_rd, Zout_valid and err.

**Operand forwarding**, priority newest first:
1. the S2 result being computed (producer in S1→S2 register);
2. the S2→S3 register (producer about to write back);
3. regbank.

A source forwards only if that producer is valid, writes registers, and its rd matches the source index. With REG0_ZERO set, index 0 always yields 0.

**Reset** (asserted):
- all stage valid bits cleared;
- Zout=0, Zout_rd=0, Zout_valid=0, err=0;
- regbank cleared to 0;
- membank not reset;
- instructions in flight are discarded with no writes.

## Timing
- Instruction accepted at edge t (in_valid=1) appears on Zout/Zout_valid after edge t+2, i.e. latency 3 edges.
- regbank and membank are updated at edge t+2.
- Throughput is one instruction per cycle; the pipeline never stalls, and in_valid=0 inserts a bubble.
- Back-to-back RAW at distance 1 or 2 gets the forwarded value; at distance ≥3 it reads regbank.
- Zout_valid is a one-cycle pulse per retired instruction. Between retirements Zout holds its last value.
- Same-cycle store and readback to one address: mem_rdata shows the old value until after the edge.
- Two instructions with the same rd in flight: the younger value wins in forwarding and in regbank.
- Reset deassertion: the first instruction is accepted at the first edge after release.

## Structure
- Shared package alu_pipeline_pkg holds the opcode constants (OP_ADD … OP_NOP), the is_legal/writes_reg helper functions, and the DATA_W/REG_AW/MEM_AW defaults.
- One sub-module, alu_pipeline_exec: a purely combinational ALU with func, A, B and imm as inputs and the result and illegal flag as outputs. It is shared by the S2 datapath and the S1 forwarding path.
- Register bank, memory bank and forwarding mux live in the top level.

## Test plan
Defaults throughout (DATA_W=16, REG_AW=4, MEM_AW=8, REG0_ZERO=0).

1. Immediate load and add: LI r1=0x0003, LI r2=0x0005, then two bubbles, then ADD r3=r1+r2 with st_en=1, addr=0x10 → Zout=0x0008 on the third cycle after issue, regbank r3=0x0008, mem_rdata@0x10=0x0008.
2. Forwarding, back to back: LI r1=0x7FFF, then ADD r2=r1+r1 immediately, then SUB r3=r2−r1 immediately → Zout sequence 0x7FFF, 0xFFFE, 0x7FFF with no bubbles.
3. Wrap and truncation: MUL with r1=0x0100, r2=0x0100 → 0x0000; SUB with r1=0, r2=1 → 0xFFFF; SHL with B=0x8001 → 0x0002; SHR with A=0x8001 → 0x4000.
4. Illegal opcode and NOP: func=14 with rd=r4, st_en=1, addr=0x20 → Zout_valid=1, err=1, Zout=0; r4 and mem[0x20] unchanged. NOP → no writes and err=0.
5. REG0_ZERO=1: LI r0=0x1234, then MOVA from r0 → Zout=0x0000, including on the forwarded path.
6. Reset mid-flight: issue three LI, then assert Reset_n low asynchronously between edges after the second edge → outputs zero immediately and no regbank/membank writes; after release, a new LI retires normally with latency 3.

Source files
------------

// File: rtl/alu_pipeline_pkg.sv
// Shared opcode constants, size defaults and decode helpers for the ALU pipeline.
// Latency: none (package); backpressure: not applicable.
package alu_pipeline_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;
    localparam int MEM_AW_DEF = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_MOVA = 4'd3;
    localparam logic [3:0] OP_MOVB = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOTA = 4'd8;
    localparam logic [3:0] OP_NOTB = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_LI   = 4'd12;
    localparam logic [3:0] OP_NOP  = 4'd13;

    function automatic logic is_legal(input logic [3:0] func);
        return func <= OP_NOP;
    endfunction

    // Every legal op except NOP produces a register result (and may store).
    function automatic logic writes_reg(input logic [3:0] func);
        return func < OP_NOP;
    endfunction

endpackage

// File: rtl/alu_pipeline_p_if.sv
// Instruction/result bus between sequencer, ALU pipeline and memory readback.
// Latency: wires only; backpressure: none, the pipeline accepts every cycle.
interface alu_pipeline_p_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
);
    logic              in_valid;
    logic [3:0]        func;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic              st_en;
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] Zout;
    logic              Zout_valid;
    logic [REG_AW-1:0] Zout_rd;
    logic              err;

    modport master (
        output in_valid, func, rs1, rs2, rd, imm, st_en, addr, mem_raddr,
        input  mem_rdata, Zout, Zout_valid, Zout_rd, err
    );

    modport slave (
        input  in_valid, func, rs1, rs2, rd, imm, st_en, addr, mem_raddr,
        output mem_rdata, Zout, Zout_valid, Zout_rd, err
    );
endinterface

// File: rtl/alu_pipeline_exec.sv
// Combinational ALU shared by the execute stage and the operand-forwarding path.
// Latency: 0 cycles; backpressure: none.
module alu_pipeline_exec
    import alu_pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);

    always_comb begin
        result  = '0;
        illegal = !is_legal(func);
        case (func)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_MOVA: result = a;
            OP_MOVB: result = b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOTA: result = ~a;
            OP_NOTB: result = ~b;
            OP_SHR:  result = a >> 1;
            OP_SHL:  result = b << 1;
            OP_LI:   result = imm;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipeline_p.sv
// Three-stage ALU pipeline (fetch/forward, execute, writeback+store); result 3 edges after issue.
// Never stalls: one instruction per cycle, in_valid=0 inserts a bubble; no backpressure.
module alu_pipeline_p
    import alu_pipeline_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int MEM_AW    = MEM_AW_DEF,
    parameter int REG0_ZERO = 0
) (
    input logic           Clock,
    input logic           Reset_n,
    alu_pipeline_p_if.slave bus
);

    localparam int REG_N = 1 << REG_AW;
    localparam int MEM_N = 1 << MEM_AW;

    logic [DATA_W-1:0] regbank [REG_N];
    logic [DATA_W-1:0] membank [MEM_N];

    logic              s1_valid, s1_st_en;
    logic [3:0]        s1_func;
    logic [REG_AW-1:0] s1_rd;
    logic [MEM_AW-1:0] s1_addr;
    logic [DATA_W-1:0] s1_a, s1_b, s1_imm;

    logic              s2_valid, s2_wr, s2_illegal, s2_st_en;
    logic [REG_AW-1:0] s2_rd;
    logic [MEM_AW-1:0] s2_addr;
    logic [DATA_W-1:0] s2_result;

    logic [DATA_W-1:0] ex_result, op_a, op_b;
    logic              ex_illegal, s1_wr;

    assign s1_wr = writes_reg(s1_func);

    alu_pipeline_exec #(.DATA_W(DATA_W)) u_exec (
        .func    (s1_func),
        .a       (s1_a),
        .b       (s1_b),
        .imm     (s1_imm),
        .result  (ex_result),
        .illegal (ex_illegal)
    );

    // Later assignments win, so the youngest producer overrides older ones.
    always_comb begin
        op_a = regbank[bus.rs1];
        if (s2_valid && s2_wr && s2_rd == bus.rs1) op_a = s2_result;
        if (s1_valid && s1_wr && s1_rd == bus.rs1) op_a = ex_result;
        if (REG0_ZERO != 0 && bus.rs1 == '0) op_a = '0;
    end

    always_comb begin
        op_b = regbank[bus.rs2];
        if (s2_valid && s2_wr && s2_rd == bus.rs2) op_b = s2_result;
        if (s1_valid && s1_wr && s1_rd == bus.rs2) op_b = ex_result;
        if (REG0_ZERO != 0 && bus.rs2 == '0) op_b = '0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge Clock) begin
        s1_func    <= bus.func;
        s1_rd      <= bus.rd;
        s1_addr    <= bus.addr;
        s1_st_en   <= bus.st_en;
        s1_a       <= op_a;
        s1_b       <= op_b;
        s1_imm     <= bus.imm;
        s2_wr      <= s1_wr;
        s2_illegal <= ex_illegal;
        s2_rd      <= s1_rd;
        s2_addr    <= s1_addr;
        s2_st_en   <= s1_st_en;
        s2_result  <= ex_result;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < REG_N; i++) regbank[i] <= '0;
        end else if (s2_valid && s2_wr && !(REG0_ZERO != 0 && s2_rd == '0)) begin
            regbank[s2_rd] <= s2_result;
        end
    end

    // Memory contents survive reset; a cleared s2_valid blocks any in-flight store.
    always_ff @(posedge Clock) begin
        if (s2_valid && s2_wr && s2_st_en) membank[s2_addr] <= s2_result;
    end

    assign bus.mem_rdata = membank[bus.mem_raddr];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Zout       <= '0;
            bus.Zout_rd    <= '0;
            bus.Zout_valid <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.Zout_valid <= s2_valid;
            bus.err        <= s2_valid && s2_illegal;
            if (s2_valid) begin
                bus.Zout    <= s2_result;
                bus.Zout_rd <= s2_rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipeline_p.sv
// Directed bench for alu_pipeline_p: default instance plus a REG0_ZERO=1 instance on the same stimulus.
module tb_alu_pipeline_p;
    import alu_pipeline_pkg::*;

    logic Clock = 1'b0;
    logic Reset_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 Clock = ~Clock;

    alu_pipeline_p_if #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) b0 ();
    alu_pipeline_p_if #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) b1 ();

    assign b1.in_valid  = b0.in_valid;
    assign b1.func      = b0.func;
    assign b1.rs1       = b0.rs1;
    assign b1.rs2       = b0.rs2;
    assign b1.rd        = b0.rd;
    assign b1.imm       = b0.imm;
    assign b1.st_en     = b0.st_en;
    assign b1.addr      = b0.addr;
    assign b1.mem_raddr = b0.mem_raddr;

    alu_pipeline_p #(.DATA_W(16), .REG_AW(4), .MEM_AW(8), .REG0_ZERO(0)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n), .bus(b0));
    alu_pipeline_p #(.DATA_W(16), .REG_AW(4), .MEM_AW(8), .REG0_ZERO(1)) dut1 (
        .Clock(Clock), .Reset_n(Reset_n), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One retirement on the default instance: valid pulse, no error, value and destination.
    task automatic ret(input string tag, input int z, input int rd);
        chk({tag, "_vld"}, 32'(b0.Zout_valid), 32'd1);
        chk({tag, "_err"}, 32'(b0.err), 32'd0);
        chk({tag, "_z"}, 32'(b0.Zout), 32'(z) & 32'hFFFF);
        chk({tag, "_rd"}, 32'(b0.Zout_rd), 32'(rd));
    endtask

    task automatic drive(input int v, input int f, input int s1, input int s2, input int d,
                         input int im, input int st, input int ad);
        b0.in_valid = 1'(v);
        b0.func     = 4'(f);
        b0.rs1      = 4'(s1);
        b0.rs2      = 4'(s2);
        b0.rd       = 4'(d);
        b0.imm      = 16'(im);
        b0.st_en    = 1'(st);
        b0.addr     = 8'(ad);
    endtask

    task automatic step(input int v, input int f, input int s1, input int s2, input int d,
                        input int im, input int st, input int ad);
        drive(v, f, s1, s2, d, im, st, ad);
        @(posedge Clock);
        #1;
    endtask

    task automatic bubble();
        step(0, OP_NOP, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset_n      = 1'b0;
        b0.mem_raddr = 8'h00;
        drive(0, OP_NOP, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_zout", 32'(b0.Zout), 32'h0);
        chk("rst_vld", 32'(b0.Zout_valid), 32'h0);
        chk("rst_rd", 32'(b0.Zout_rd), 32'h0);
        chk("rst_err", 32'(b0.err), 32'h0);
        Reset_n = 1'b1;

        // Immediate loads, then ADD from regbank with a store.
        step(1, OP_LI, 0, 0, 1, 'h0003, 0, 0);
        step(1, OP_LI, 0, 0, 2, 'h0005, 0, 0);
        bubble();
        ret("t1_li1", 'h3, 1);
        bubble();
        ret("t1_li2", 'h5, 2);
        step(1, OP_ADD, 1, 2, 3, 0, 1, 'h10);
        chk("t1_bubble_vld", 32'(b0.Zout_valid), 32'h0);
        chk("t1_hold_z", 32'(b0.Zout), 32'h5);
        bubble();
        bubble();
        ret("t1_add", 'h8, 3);
        b0.mem_raddr = 8'h10;
        #1;
        chk("t1_mem10", 32'(b0.mem_rdata), 32'h8);
        step(1, OP_MOVA, 3, 0, 6, 0, 0, 0);
        bubble();
        bubble();
        ret("t1_r3", 'h8, 6);

        // Back-to-back dependents through both forwarding sources.
        step(1, OP_LI, 0, 0, 1, 'h7FFF, 0, 0);
        step(1, OP_ADD, 1, 1, 2, 0, 0, 0);
        step(1, OP_SUB, 2, 1, 3, 0, 0, 0);
        ret("t2_li", 'h7FFF, 1);
        step(1, OP_MOVA, 3, 0, 5, 0, 0, 0);
        ret("t2_add", 'hFFFE, 2);
        bubble();
        ret("t2_sub", 'h7FFF, 3);
        bubble();
        ret("t2_mova", 'h7FFF, 5);

        // Wrap and truncation cases.
        step(1, OP_LI, 0, 0, 1, 'h0100, 0, 0);
        step(1, OP_LI, 0, 0, 2, 'h0100, 0, 0);
        step(1, OP_MUL, 1, 2, 4, 0, 0, 0);
        step(1, OP_LI, 0, 0, 7, 'h0000, 0, 0);
        step(1, OP_LI, 0, 0, 8, 'h0001, 0, 0);
        ret("t3_mul", 'h0000, 4);
        step(1, OP_SUB, 7, 8, 9, 0, 0, 0);
        step(1, OP_LI, 0, 0, 10, 'h8001, 0, 0);
        step(1, OP_SHL, 0, 10, 11, 0, 0, 0);
        ret("t3_sub", 'hFFFF, 9);
        step(1, OP_SHR, 10, 0, 12, 0, 0, 0);
        bubble();
        ret("t3_shl", 'h0002, 11);
        bubble();
        ret("t3_shr", 'h4000, 12);

        // Illegal op and NOP must neither write nor forward.
        step(1, OP_LI, 0, 0, 4, 'hAAAA, 1, 'h20);
        step(1, 14, 1, 2, 4, 'h5555, 1, 'h20);
        step(1, OP_MOVA, 4, 0, 13, 0, 0, 0);
        ret("t4_li", 'hAAAA, 4);
        step(1, OP_NOP, 1, 2, 4, 'h1234, 1, 'h20);
        chk("t4_ill_vld", 32'(b0.Zout_valid), 32'h1);
        chk("t4_ill_err", 32'(b0.err), 32'h1);
        chk("t4_ill_z", 32'(b0.Zout), 32'h0);
        chk("t4_ill_rd", 32'(b0.Zout_rd), 32'h4);
        bubble();
        ret("t4_mova", 'hAAAA, 13);
        bubble();
        ret("t4_nop", 'h0, 4);
        b0.mem_raddr = 8'h20;
        #1;
        chk("t4_mem20", 32'(b0.mem_rdata), 32'hAAAA);
        bubble();
        chk("t4_idle_vld", 32'(b0.Zout_valid), 32'h0);
        chk("t4_idle_err", 32'(b0.err), 32'h0);

        // Register 0 behaviour: hardwired zero on dut1, ordinary register on dut0.
        step(1, OP_LI, 0, 0, 0, 'h1234, 0, 0);
        step(1, OP_MOVA, 0, 0, 14, 0, 0, 0);
        bubble();
        chk("t5_li_z1", 32'(b1.Zout), 32'h1234);
        bubble();
        chk("t5_fwd_vld1", 32'(b1.Zout_valid), 32'h1);
        chk("t5_fwd_z1", 32'(b1.Zout), 32'h0);
        chk("t5_fwd_z0", 32'(b0.Zout), 32'h1234);
        step(1, OP_MOVA, 0, 0, 14, 0, 0, 0);
        bubble();
        bubble();
        chk("t5_rf_z1", 32'(b1.Zout), 32'h0);
        chk("t5_rf_z0", 32'(b0.Zout), 32'h1234);

        // Asynchronous reset with instructions in flight.
        step(1, OP_LI, 0, 0, 15, 'h0BAD, 1, 'h30);
        bubble();
        bubble();
        ret("t6_pre", 'h0BAD, 15);
        step(1, OP_LI, 0, 0, 1, 'h1111, 1, 'h30);
        step(1, OP_LI, 0, 0, 2, 'h2222, 1, 'h30);
        drive(1, OP_LI, 0, 0, 3, 'h3333, 1, 'h30);
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_z", 32'(b0.Zout), 32'h0);
        chk("t6_rst_rd", 32'(b0.Zout_rd), 32'h0);
        chk("t6_rst_vld", 32'(b0.Zout_valid), 32'h0);
        drive(0, OP_NOP, 0, 0, 0, 0, 0, 0);
        @(posedge Clock);
        #1;
        Reset_n      = 1'b1;
        b0.mem_raddr = 8'h30;
        #1;
        chk("t6_mem30", 32'(b0.mem_rdata), 32'h0BAD);
        step(1, OP_LI, 0, 0, 5, 'h5A5A, 0, 0);
        bubble();
        chk("t6_lat_vld", 32'(b0.Zout_valid), 32'h0);
        bubble();
        ret("t6_li", 'h5A5A, 5);
        step(1, OP_OR, 1, 15, 6, 0, 0, 0);
        bubble();
        bubble();
        ret("t6_rf_clear", 'h0, 6);
        chk("t6_mem30_after", 32'(b0.mem_rdata), 32'h0BAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
